motion_input_ctrl: RTL and testbench
====================================

Name: motion_input_ctrl

Overview:
- Sits directly upstream of the ball motion block.
- Decodes up to four simultaneous USB HID keycodes (W/A/S/D movement, Space dash) into a packed per-frame signed velocity word, vel = {vy, vx}, consumed as the ball's 16-bit keycode input.
- Adds acceleration, friction decay, speed clamping and a timed dash with cooldown, all updated once per frame.

Parameters:
ACCEL, 1, velocity increment per frame while a direction is held
FRICTION, 1, per-frame decay toward 0 when an axis has no net direction
MAX_SPEED, 4, normal-mode magnitude clamp; legal range 1..127
DASH_SPEED, 12, magnitude applied on the dash axes; legal range MAX_SPEED..127
DASH_FRAMES, 8, frames the dash velocity is held; legal range >=1
COOLDOWN_FRAMES, 30, frames after a dash during which Space is ignored; legal range >=1

Ports:
frame_clk  in  1  frame clock, one rising edge per video frame
Reset_n  in  1  asynchronous active-low reset
keycodes  in  32  four 8-bit HID keycode slots; 0x00 means empty
vel  out  16  {vy[15:8], vx[7:0]}, each 8-bit two's complement, range -127..127
dashing  out  1  high while in DASH
cooldown  out  1  high while in COOLDOWN

Behaviour:
- Key decode (combinational): a key is pressed if any of the 4 slots equals its code. W=0x1A, A=0x04, S=0x16, D=0x07, Space=0x2C.
- Direction per axis:
  - dir_x = +1 if D and not A; -1 if A and not D; else 0.
  - dir_y = +1 (down) if S and not W; -1 if W and not S; else 0.
- Reset (async, Reset_n=0):
  - vx=vy=0, state=NORMAL, dash/cooldown counters=0, latched dirs=0, space_prev=1.
  - space_prev=1 means a Space held through reset release does not dash.
  - Outputs: vel=0x0000, dashing=0, cooldown=0. Reset mid-dash or mid-cooldown takes effect immediately.
- All updates occur on the frame_clk rising edge. Outputs are registered; there is one frame of latency from keycodes to vel.
- Physics update (NORMAL and COOLDOWN), per axis, in 10-bit signed arithmetic:
  - dir!=0: v_next = v + dir*ACCEL, clamped to [-MAX_SPEED, +MAX_SPEED]. Reversal uses the same rule; no extra braking.
  - dir==0: if |v| <= FRICTION then v_next = 0, else v moves toward 0 by FRICTION. Never crosses zero.
  - The result is truncated to 8 bits only after clamping. vx=-128 is never produced.
- space_edge = Space pressed this frame and space_prev==0. space_prev updates every frame in every state.
- State machine:
  - NORMAL:
    - space_edge and (dir_x!=0 or dir_y!=0): go to DASH, latch dir_x/dir_y, set v = dir_latched*DASH_SPEED per axis (0 on an axis with no direction), dash_cnt = DASH_FRAMES-1.
    - space_edge with no direction: ignored; physics update applies.
  - DASH:
    - dash_cnt!=0: vel held, dash_cnt decrements; key inputs other than reset are ignored.
    - dash_cnt==0: go to COOLDOWN, v = dir_latched*MAX_SPEED per axis, cd_cnt = COOLDOWN_FRAMES-1.
    - Net effect: dash velocity is visible for exactly DASH_FRAMES frames.
  - COOLDOWN:
    - Physics update applies; space_edge is ignored.
    - cd_cnt!=0: cd_cnt decrements.
    - cd_cnt==0: go to NORMAL. A space_edge on this same edge is not honoured.
- dashing = (state==DASH); cooldown = (state==COOLDOWN).
- Duplicate keycodes across slots behave the same as one instance.
- Parameter legality is checked by an elaboration-time assertion.

Test Plan:
1. From reset, hold D (keycodes=0x00000007) 6 frames -> vx after each edge: 1,2,3,4,4,4 (vel=0x0004); release -> 3,2,1,0,0.
2. vx=4, hold A -> 3,2,1,0,-1,-2,-3,-4,-4 (vel[7:0]=0xFC). Hold A+D (0x00000407) -> decays -3,-2,-1,0; dir=0.
3. Hold D+S at vx=vy=4, press Space (0x2C160007) -> next edge vel=0x0C0C, dashing=1 for exactly 8 frames. Then vel=0x0404, cooldown=1 for 30 frames, then cooldown=0.
4. During cooldown, release and re-press Space -> no dash (dashing stays 0). After cooldown ends, a new Space edge with D held -> vx=0x0C.
5. Hold Space across Reset_n release with W held -> no dash; vy ramps -1..-4 (vel[15:8]=0xFC). Space alone with no direction -> dashing stays 0.
6. Assert Reset_n=0 asynchronously mid-dash (between edges) -> vel=0x0000, dashing=0, cooldown=0 immediately, without waiting for a frame_clk edge.

Source files
------------

// File: rtl/motion_input_ctrl_if.sv
// Keyboard-to-ball link: HID keycode slots in, packed velocity and dash status out.
interface motion_input_ctrl_if;
   logic [31:0] keycodes;
   logic [15:0] vel;
   logic        dashing;
   logic        cooldown;

   modport master (output keycodes, input vel, dashing, cooldown);
   modport slave  (input keycodes, output vel, dashing, cooldown);
endinterface

// File: rtl/motion_input_ctrl.sv
// Turns W/A/S/D/Space keycodes into a per-frame {vy, vx} velocity word with
// acceleration, friction, speed clamping and a timed dash followed by a cooldown.
module motion_input_ctrl #(
   parameter int ACCEL           = 1,
   parameter int FRICTION        = 1,
   parameter int MAX_SPEED       = 4,
   parameter int DASH_SPEED      = 12,
   parameter int DASH_FRAMES     = 8,
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic                 frame_clk,
   input  logic                 Reset_n,
   motion_input_ctrl_if.slave   bus
);

   if (MAX_SPEED < 1 || MAX_SPEED > 127 || DASH_SPEED < MAX_SPEED || DASH_SPEED > 127 ||
       DASH_FRAMES < 1 || COOLDOWN_FRAMES < 1) begin : g_bad_params
      $error("motion_input_ctrl: illegal parameter combination");
   end

   localparam logic [1:0] NORMAL   = 2'd0;
   localparam logic [1:0] DASH     = 2'd1;
   localparam logic [1:0] COOLDOWN = 2'd2;

   localparam int DW = (DASH_FRAMES > 1) ? $clog2(DASH_FRAMES) : 1;
   localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

   localparam logic signed [9:0] ACC10 = 10'(ACCEL);
   localparam logic signed [9:0] FRI10 = 10'(FRICTION);
   localparam logic signed [9:0] MAX10 = 10'(MAX_SPEED);
   localparam logic signed [1:0] POS   = 2'sb01;
   localparam logic signed [1:0] NEG   = 2'sb11;

   logic [1:0]        state;
   logic signed [7:0] vx, vy;
   logic signed [1:0] lat_x, lat_y;
   logic [DW-1:0]     dash_cnt;
   logic [CW-1:0]     cd_cnt;
   logic              space_prev;

   logic              key_w, key_a, key_s, key_d, key_space, space_edge;
   logic signed [1:0] dir_x, dir_y;

   function automatic logic has_key(input logic [31:0] kc, input logic [7:0] code);
      return (kc[7:0] == code) || (kc[15:8] == code) || (kc[23:16] == code) || (kc[31:24] == code);
   endfunction

   // Widened to 10 bits so the add/clamp cannot wrap before truncation.
   function automatic logic [7:0] step_axis(input logic signed [7:0] v, input logic signed [1:0] dir);
      logic signed [9:0] w;
      logic signed [9:0] n;
      w = {{2{v[7]}}, v};
      if (dir == POS) begin
         n = w + ACC10;
         if (n > MAX10) n = MAX10;
      end else if (dir == NEG) begin
         n = w - ACC10;
         if (n < -MAX10) n = -MAX10;
      end else if (w > FRI10) begin
         n = w - FRI10;
      end else if (w < -FRI10) begin
         n = w + FRI10;
      end else begin
         n = '0;
      end
      return n[7:0];
   endfunction

   function automatic logic [7:0] scale(input logic signed [1:0] dir, input logic [7:0] mag);
      logic [7:0] r;
      r = 8'd0;
      if (dir == POS) r = mag;
      else if (dir == NEG) r = ~mag + 8'd1;
      return r;
   endfunction

   always_comb begin
      key_w      = has_key(bus.keycodes, 8'h1A);
      key_a      = has_key(bus.keycodes, 8'h04);
      key_s      = has_key(bus.keycodes, 8'h16);
      key_d      = has_key(bus.keycodes, 8'h07);
      key_space  = has_key(bus.keycodes, 8'h2C);
      space_edge = key_space && !space_prev;
      dir_x = 2'sb00;
      if (key_d && !key_a) dir_x = POS;
      else if (key_a && !key_d) dir_x = NEG;
      dir_y = 2'sb00;
      if (key_s && !key_w) dir_y = POS;
      else if (key_w && !key_s) dir_y = NEG;
   end

   // space_prev resets high so a Space held through reset release is not an edge.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= NORMAL;
         vx         <= '0;
         vy         <= '0;
         lat_x      <= '0;
         lat_y      <= '0;
         dash_cnt   <= '0;
         cd_cnt     <= '0;
         space_prev <= 1'b1;
      end else begin
         space_prev <= key_space;
         case (state)
            NORMAL: begin
               if (space_edge && (dir_x != 2'sb00 || dir_y != 2'sb00)) begin
                  state    <= DASH;
                  lat_x    <= dir_x;
                  lat_y    <= dir_y;
                  vx       <= scale(dir_x, 8'(DASH_SPEED));
                  vy       <= scale(dir_y, 8'(DASH_SPEED));
                  dash_cnt <= DW'(DASH_FRAMES - 1);
               end else begin
                  vx <= step_axis(vx, dir_x);
                  vy <= step_axis(vy, dir_y);
               end
            end
            DASH: begin
               if (dash_cnt != '0) begin
                  dash_cnt <= dash_cnt - DW'(1);
               end else begin
                  state  <= COOLDOWN;
                  vx     <= scale(lat_x, 8'(MAX_SPEED));
                  vy     <= scale(lat_y, 8'(MAX_SPEED));
                  cd_cnt <= CW'(COOLDOWN_FRAMES - 1);
               end
            end
            COOLDOWN: begin
               vx <= step_axis(vx, dir_x);
               vy <= step_axis(vy, dir_y);
               if (cd_cnt != '0) cd_cnt <= cd_cnt - CW'(1);
               else state <= NORMAL;
            end
            default: state <= NORMAL;
         endcase
      end
   end

   assign bus.vel      = {vy, vx};
   assign bus.dashing  = (state == DASH);
   assign bus.cooldown = (state == COOLDOWN);

endmodule

// File: tb/tb_motion_input_ctrl.sv
// Directed bench for motion_input_ctrl: ramps, reversal, dash/cooldown timing and async reset.
module tb_motion_input_ctrl;

   logic frame_clk;
   logic Reset_n;
   int   vectors;
   int   miscompares;

   motion_input_ctrl_if bus ();

   motion_input_ctrl dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .bus       (bus)
   );

   initial begin
      frame_clk = 1'b0;
      forever #5 frame_clk = ~frame_clk;
   end

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic test_reset();
      Reset_n      = 1'b0;
      bus.keycodes = 32'h0;
      #23;
      vectors++;
      if (bus.vel !== 16'h0000 || bus.dashing !== 1'b0 || bus.cooldown !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset: vel=%h dashing=%b cooldown=%b, want 0000/0/0",
                  bus.vel, bus.dashing, bus.cooldown);
      end
      @(posedge frame_clk);
      #3 Reset_n = 1'b1;
      #1;
   endtask

   task automatic test_ramp();
      logic [7:0] up [6]   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
      logic [7:0] down [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
      bus.keycodes = 32'h0000_0007;
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if (bus.vel !== {8'h00, up[i]}) begin
            miscompares++;
            $display("[TB] FAIL ramp_up[%0d]: vel=%h want %h", i, bus.vel, {8'h00, up[i]});
         end
      end
      bus.keycodes = 32'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (bus.vel !== {8'h00, down[i]}) begin
            miscompares++;
            $display("[TB] FAIL friction[%0d]: vel=%h want %h", i, bus.vel, {8'h00, down[i]});
         end
      end
   endtask

   task automatic test_reversal();
      logic [7:0] rev [9] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFC};
      logic [7:0] cancel [4] = '{8'hFD, 8'hFE, 8'hFF, 8'h00};
      bus.keycodes = 32'h0000_0007;
      for (int i = 0; i < 4; i++) tick();
      vectors++;
      if (bus.vel !== 16'h0004) begin
         miscompares++;
         $display("[TB] FAIL reversal_setup: vel=%h want 0004", bus.vel);
      end
      bus.keycodes = 32'h0000_0004;
      for (int i = 0; i < 9; i++) begin
         tick();
         vectors++;
         if (bus.vel !== {8'h00, rev[i]}) begin
            miscompares++;
            $display("[TB] FAIL reversal[%0d]: vel=%h want %h", i, bus.vel, {8'h00, rev[i]});
         end
      end
      bus.keycodes = 32'h0000_0407;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (bus.vel !== {8'h00, cancel[i]}) begin
            miscompares++;
            $display("[TB] FAIL a_plus_d[%0d]: vel=%h want %h", i, bus.vel, {8'h00, cancel[i]});
         end
      end
   endtask

   task automatic test_dash();
      bus.keycodes = 32'h0000_1607;
      for (int i = 0; i < 4; i++) tick();
      vectors++;
      if (bus.vel !== 16'h0404) begin
         miscompares++;
         $display("[TB] FAIL dash_setup: vel=%h want 0404", bus.vel);
      end
      bus.keycodes = 32'h2C16_0007;
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (bus.vel !== 16'h0C0C || bus.dashing !== 1'b1 || bus.cooldown !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dash_frame[%0d]: vel=%h dashing=%b cooldown=%b, want 0c0c/1/0",
                     i, bus.vel, bus.dashing, bus.cooldown);
         end
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         vectors++;
         if (bus.vel !== 16'h0404 || bus.dashing !== 1'b0 || bus.cooldown !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cooldown_frame[%0d]: vel=%h dashing=%b cooldown=%b, want 0404/0/1",
                     i, bus.vel, bus.dashing, bus.cooldown);
         end
      end
      tick();
      vectors++;
      if (bus.vel !== 16'h0404 || bus.dashing !== 1'b0 || bus.cooldown !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL cooldown_end: vel=%h dashing=%b cooldown=%b, want 0404/0/0",
                  bus.vel, bus.dashing, bus.cooldown);
      end
   endtask

   task automatic test_cooldown_lockout();
      bus.keycodes = 32'h0016_0007;
      tick();
      bus.keycodes = 32'h2C16_0007;
      tick();
      for (int i = 0; i < 7; i++) tick();
      vectors++;
      if (bus.dashing !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL redash_last_frame: dashing=%b want 1", bus.dashing);
      end
      // Space toggles every frame while cooling down; none of the edges may dash.
      for (int i = 0; i < 30; i++) begin
         bus.keycodes = (i % 2 == 0) ? 32'h2C16_0007 : 32'h0016_0007;
         tick();
         vectors++;
         if (bus.dashing !== 1'b0 || bus.cooldown !== 1'b1 || bus.vel !== 16'h0404) begin
            miscompares++;
            $display("[TB] FAIL lockout[%0d]: vel=%h dashing=%b cooldown=%b, want 0404/0/1",
                     i, bus.vel, bus.dashing, bus.cooldown);
         end
      end
      bus.keycodes = 32'h2C00_0007;
      tick();
      vectors++;
      if (bus.vel !== 16'h0304 || bus.dashing !== 1'b0 || bus.cooldown !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL exit_edge_ignored: vel=%h dashing=%b cooldown=%b, want 0304/0/0",
                  bus.vel, bus.dashing, bus.cooldown);
      end
      bus.keycodes = 32'h0000_0007;
      tick();
      vectors++;
      if (bus.vel !== 16'h0204) begin
         miscompares++;
         $display("[TB] FAIL post_cooldown: vel=%h want 0204", bus.vel);
      end
      bus.keycodes = 32'h2C00_0007;
      tick();
      vectors++;
      if (bus.vel !== 16'h000C || bus.dashing !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL new_dash_x: vel=%h dashing=%b, want 000c/1", bus.vel, bus.dashing);
      end
   endtask

   task automatic test_async_reset();
      tick();
      vectors++;
      if (bus.dashing !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL pre_reset_dash: dashing=%b want 1", bus.dashing);
      end
      #2 Reset_n = 1'b0;
      #1;
      vectors++;
      if (bus.vel !== 16'h0000 || bus.dashing !== 1'b0 || bus.cooldown !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: vel=%h dashing=%b cooldown=%b, want 0000/0/0",
                  bus.vel, bus.dashing, bus.cooldown);
      end
   endtask

   task automatic test_space_through_reset();
      logic [7:0] vy_exp [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
      bus.keycodes = 32'h2C00_001A;
      @(posedge frame_clk);
      #3 Reset_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (bus.vel !== {vy_exp[i], 8'h00} || bus.dashing !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_space_w[%0d]: vel=%h dashing=%b, want %h/0",
                     i, bus.vel, bus.dashing, {vy_exp[i], 8'h00});
         end
      end
      bus.keycodes = 32'h0;
      tick();
      bus.keycodes = 32'h0000_002C;
      tick();
      vectors++;
      if (bus.vel !== 16'hFE00 || bus.dashing !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL space_no_dir: vel=%h dashing=%b, want fe00/0", bus.vel, bus.dashing);
      end
      bus.keycodes = 32'h0707_0707;
      tick();
      vectors++;
      if (bus.vel !== 16'hFF01) begin
         miscompares++;
         $display("[TB] FAIL duplicate_slots: vel=%h want ff01", bus.vel);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_ramp();
      test_reversal();
      test_dash();
      test_cooldown_lockout();
      test_async_reset();
      test_space_through_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
